// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter: write-port arbiter and busy scoreboard for RV32I RF  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_valid,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_ready,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_address,
  input  logic [4:0]      rs2_address,
  input  logic [4:0]      dec_rd,
  output logic            hazard_rs1,
  output logic            hazard_rs2,
  output logic            hazard_rd,
  output logic            en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] register_file_data
);

  logic            prio_q, prio_d;
  logic [31:0]     busy_q, busy_d;
  logic            pend_q, pend_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic            en_q, en_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;

  logic w_both;
  logic w_pipe_gnt;
  logic w_lu_gnt;

  assign w_both     = pipe_valid & lu_valid;
  assign w_pipe_gnt = pipe_valid & (~lu_valid | ~prio_q);
  assign w_lu_gnt   = lu_valid & (~pipe_valid | prio_q);

  assign pipe_ready = w_pipe_gnt;
  assign lu_ready   = w_lu_gnt;

  always_comb begin
    prio_d = prio_q;
    if (w_both) begin
      prio_d = ~prio_q;
    end
  end

  always_comb begin
    en_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (w_pipe_gnt) begin
      en_d   = (pipe_rd != 5'd0);
      rd_d   = pipe_rd;
      data_d = pipe_data;
    end else if (w_lu_gnt) begin
      en_d   = (lu_rd != 5'd0);
      rd_d   = lu_rd;
      data_d = lu_data;
    end
  end

  // The clear trails the grant by one extra edge so the hazard covers the cycle en is high.
  always_comb begin
    pend_d    = w_lu_gnt && (lu_rd != 5'd0);
    pend_rd_d = lu_rd;
    busy_d    = busy_q;
    if (pend_q) begin
      busy_d[pend_rd_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= 1'b0;
      busy_q    <= '0;
      pend_q    <= 1'b0;
      pend_rd_q <= 5'd0;
      en_q      <= 1'b0;
      rd_q      <= 5'd0;
      data_q    <= '0;
    end else begin
      prio_q    <= prio_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      pend_rd_q <= pend_rd_d;
      en_q      <= en_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
    end
  end

  assign hazard_rs1         = busy_q[rs1_address];
  assign hazard_rs2         = busy_q[rs2_address];
  assign hazard_rd          = busy_q[dec_rd];
  assign en                 = en_q;
  assign rd                 = rd_q;
  assign register_file_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter: directed self-checking bench for the WB arbiter   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_valid;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            pipe_ready;
  logic            lu_valid;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            lu_ready;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1_address;
  logic [4:0]      rs2_address;
  logic [4:0]      dec_rd;
  logic            hazard_rs1;
  logic            hazard_rs2;
  logic            hazard_rd;
  logic            en;
  logic [4:0]      rd;
  logic [XLEN-1:0] register_file_data;

  int n_pass  = 0;
  int n_total = 0;

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk                (clk),
    .rst                (rst),
    .pipe_valid         (pipe_valid),
    .pipe_rd            (pipe_rd),
    .pipe_data          (pipe_data),
    .pipe_ready         (pipe_ready),
    .lu_valid           (lu_valid),
    .lu_rd              (lu_rd),
    .lu_data            (lu_data),
    .lu_ready           (lu_ready),
    .issue_valid        (issue_valid),
    .issue_rd           (issue_rd),
    .rs1_address        (rs1_address),
    .rs2_address        (rs2_address),
    .dec_rd             (dec_rd),
    .hazard_rs1         (hazard_rs1),
    .hazard_rs2         (hazard_rs2),
    .hazard_rd          (hazard_rd),
    .en                 (en),
    .rd                 (rd),
    .register_file_data (register_file_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge; inputs change only here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid  = 1'b0;
    pipe_rd     = 5'd0;
    pipe_data   = '0;
    lu_valid    = 1'b0;
    lu_rd       = 5'd0;
    lu_data     = '0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
  endtask

  initial begin
    idle_inputs();
    rst         = 1'b1;
    rs1_address = 5'd3;
    rs2_address = 5'd3;
    dec_rd      = 5'd3;
    next_cycle();

    // Reset held two cycles with live requests and an issue to x3.
    for (int i = 0; i < 2; i++) begin
      pipe_valid  = 1'b1;
      pipe_rd     = 5'($urandom_range(1, 31));
      pipe_data   = $urandom;
      lu_valid    = 1'b1;
      lu_rd       = 5'($urandom_range(1, 31));
      lu_data     = $urandom;
      issue_valid = 1'b1;
      issue_rd    = 5'd3;
      @(negedge clk);
      check_eq("rst_pipe_ready", 32'(pipe_ready), 32'd1);
      check_eq("rst_lu_ready", 32'(lu_ready), 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check_eq("rst_en", 32'(en), 32'd0);
    check_eq("rst_rd", 32'(rd), 32'd0);
    check_eq("rst_data", register_file_data, 32'd0);
    check_eq("rst_haz_rs1", 32'(hazard_rs1), 32'd0);
    check_eq("rst_haz_rs2", 32'(hazard_rs2), 32'd0);
    check_eq("rst_haz_rd", 32'(hazard_rd), 32'd0);
    next_cycle();

    // Contention: strict alternation pipe, lu, pipe, lu with no bubbles.
    for (int i = 0; i < 4; i++) begin
      pipe_valid = 1'b1;
      pipe_rd    = 5'd1;
      pipe_data  = 32'h11;
      lu_valid   = 1'b1;
      lu_rd      = 5'd2;
      lu_data    = 32'h22;
      @(negedge clk);
      check_eq("cont_pipe_ready", 32'(pipe_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("cont_lu_ready", 32'(lu_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) begin
        check_eq("cont_en", 32'(en), 32'd1);
        check_eq("cont_rd", 32'(rd), (i % 2 == 1) ? 32'd1 : 32'd2);
        check_eq("cont_data", register_file_data, (i % 2 == 1) ? 32'h11 : 32'h22);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check_eq("cont_last_en", 32'(en), 32'd1);
    check_eq("cont_last_rd", 32'(rd), 32'd2);
    check_eq("cont_last_data", register_file_data, 32'h22);
    next_cycle();
    @(negedge clk);
    check_eq("cont_idle_en", 32'(en), 32'd0);

    // Single pipe write.
    next_cycle();
    pipe_valid = 1'b1;
    pipe_rd    = 5'd5;
    pipe_data  = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("single_pipe_ready", 32'(pipe_ready), 32'd1);
    check_eq("single_lu_ready", 32'(lu_ready), 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_eq("single_en", 32'(en), 32'd1);
    check_eq("single_rd", 32'(rd), 32'd5);
    check_eq("single_data", register_file_data, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check_eq("single_en_off", 32'(en), 32'd0);
    check_eq("single_rd_hold", 32'(rd), 32'd5);
    check_eq("single_data_hold", register_file_data, 32'hDEADBEEF);

    // Scoreboard set and delayed clear on x7.
    next_cycle();
    rs1_address = 5'd7;
    rs2_address = 5'd0;
    dec_rd      = 5'd7;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    @(negedge clk);
    check_eq("sb_haz_before", 32'(hazard_rs1), 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_eq("sb_haz_rs1_set", 32'(hazard_rs1), 32'd1);
    check_eq("sb_haz_rd_set", 32'(hazard_rd), 32'd1);
    next_cycle();
    lu_valid = 1'b1;
    lu_rd    = 5'd7;
    lu_data  = 32'h77;
    @(negedge clk);
    check_eq("sb_lu_ready", 32'(lu_ready), 32'd1);
    check_eq("sb_haz_M", 32'(hazard_rs1), 32'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_eq("sb_haz_M1", 32'(hazard_rs1), 32'd1);
    check_eq("sb_hazrd_M1", 32'(hazard_rd), 32'd1);
    check_eq("sb_en_M1", 32'(en), 32'd1);
    check_eq("sb_rd_M1", 32'(rd), 32'd7);
    check_eq("sb_data_M1", register_file_data, 32'h77);
    next_cycle();
    @(negedge clk);
    check_eq("sb_haz_M2", 32'(hazard_rs1), 32'd0);
    check_eq("sb_hazrd_M2", 32'(hazard_rd), 32'd0);
    check_eq("sb_en_M2", 32'(en), 32'd0);

    // Writes and issues to x0.
    next_cycle();
    pipe_valid  = 1'b1;
    pipe_rd     = 5'd0;
    pipe_data   = 32'hFFFFFFFF;
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    @(negedge clk);
    check_eq("x0_pipe_ready", 32'(pipe_ready), 32'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_eq("x0_en", 32'(en), 32'd0);
    check_eq("x0_haz_rs2", 32'(hazard_rs2), 32'd0);

    // Set wins over a same-edge clear on x9.
    next_cycle();
    rs1_address = 5'd9;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    next_cycle();
    idle_inputs();
    lu_valid = 1'b1;
    lu_rd    = 5'd9;
    lu_data  = 32'h99;
    @(negedge clk);
    check_eq("col_lu_ready", 32'(lu_ready), 32'd1);
    check_eq("col_haz_grant", 32'(hazard_rs1), 32'd1);
    next_cycle();
    idle_inputs();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    @(negedge clk);
    check_eq("col_en", 32'(en), 32'd1);
    check_eq("col_rd", 32'(rd), 32'd9);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_eq("col_haz_after", 32'(hazard_rs1), 32'd1);
    next_cycle();
    @(negedge clk);
    check_eq("col_haz_hold", 32'(hazard_rs1), 32'd1);

    // Reset one cycle after a lu grant; a grant during reset is discarded.
    next_cycle();
    rs2_address = 5'd12;
    dec_rd      = 5'd13;
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    next_cycle();
    idle_inputs();
    issue_valid = 1'b1;
    issue_rd    = 5'd13;
    lu_valid    = 1'b1;
    lu_rd       = 5'd12;
    lu_data     = 32'hC0FFEE;
    @(negedge clk);
    check_eq("mrst_lu_ready", 32'(lu_ready), 32'd1);
    check_eq("mrst_haz12", 32'(hazard_rs2), 32'd1);
    next_cycle();
    idle_inputs();
    rst      = 1'b1;
    lu_valid = 1'b1;
    lu_rd    = 5'd13;
    lu_data  = 32'h1313;
    @(negedge clk);
    check_eq("mrst_lu_ready_in_rst", 32'(lu_ready), 32'd1);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check_eq("mrst_en", 32'(en), 32'd0);
    check_eq("mrst_rd", 32'(rd), 32'd0);
    check_eq("mrst_data", register_file_data, 32'd0);
    check_eq("mrst_haz_rs1_9", 32'(hazard_rs1), 32'd0);
    check_eq("mrst_haz_rs2_12", 32'(hazard_rs2), 32'd0);
    check_eq("mrst_haz_rd_13", 32'(hazard_rd), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("mrst_en_after", 32'(en), 32'd0);

    // Prio restarts at pipe after the mid-run reset.
    next_cycle();
    pipe_valid = 1'b1;
    pipe_rd    = 5'd4;
    pipe_data  = 32'h44;
    lu_valid   = 1'b1;
    lu_rd      = 5'd6;
    lu_data    = 32'h66;
    @(negedge clk);
    check_eq("post_rst_pipe_first", 32'(pipe_ready), 32'd1);
    check_eq("post_rst_lu_wait", 32'(lu_ready), 32'd0);
    next_cycle();
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the RV32I register file in the 5-stage pipelined CPU. It shares the register file's single write port between two requesters: the in-order pipeline write-back stage and a long-latency unit (multi-cycle load or divide). It also keeps a per-register busy scoreboard for long-latency destinations, and drives hazard flags to the decode stage so the decode stage stalls on RAW/WAW conflicts.

## Interface
- XLEN, 32, data width of register file writes
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pipe_valid  in  1  pipeline write-back request
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  XLEN  pipeline write data
- pipe_ready  out  1  pipeline request accepted this cycle (combinational)
- lu_valid  in  1  long-latency unit write-back request
- lu_rd  in  5  long-latency destination register
- lu_data  in  XLEN  long-latency write data
- lu_ready  out  1  long-latency request accepted this cycle (combinational)
- issue_valid  in  1  long-latency op dispatched this cycle
- issue_rd  in  5  destination of dispatched op
- rs1_address  in  5  decode-stage source 1
- rs2_address  in  5  decode-stage source 2
- dec_rd  in  5  decode-stage destination
- hazard_rs1  out  1  busy[rs1_address] (combinational from registered busy bits)
- hazard_rs2  out  1  busy[rs2_address]
- hazard_rd  out  1  busy[dec_rd] (WAW)
- en  out  1  register file write enable (registered)
- rd  out  5  register file write address (registered)
- register_file_data  out  XLEN  register file write data (registered)

## Operation
- A transfer completes when valid && ready is true in the same cycle.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the 1-bit round-robin pointer `prio` is granted (0 = pipe, 1 = lu).
  - `prio` updates only when both requesters are valid in the same cycle. It then points to the loser.
  - Ready is never asserted without the matching valid.
- Output register:
  - On a grant, load rd and register_file_data from the winner.
  - Load en = 1 only if the winner's rd != 0.
  - With no grant, en = 0. rd and data hold their values.
- Writes to x0 are handshaked (ready = 1) but never drive en.
- Scoreboard: busy[31:0] register, busy[0] hard-wired 0.
  - Set: issue_valid && issue_rd != 0 sets busy[issue_rd] at the next edge.
  - Clear: a lu grant with lu_rd = r sets a pending-clear. busy[r] clears at the edge that ends the cycle in which en = 1 for that write, i.e. 2 edges after the grant.
  - Clear timing consequence: the hazard stays visible until the register file holds the new value.
  - Set and clear of the same register at the same edge: set wins, busy stays 1.
- The pipe requester never modifies busy.
- issue_rd to an already-busy register is an upstream protocol violation. The decode stage must stall on hazard_rd. If it happens anyway, busy simply stays 1.
- Hazard outputs are pure decodes of busy. They do not look at the in-flight output register; the scoreboard clear timing covers that window.

## Timing
- Reset (synchronous, rst = 1 at an edge) forces:
  - en = 0, rd = 0, register_file_data = 0
  - busy = 0, pending-clear = 0
  - prio = 0
  - hazards = 0 in the next cycle
  - ready outputs still follow the arbitration equations; transfers accepted while rst = 1 are discarded.
- Reset mid-operation drops any pending-clear and all busy bits, with no write issued.
- Grant at edge N-1/N cycle → en/rd/data visible in cycle N+1 → register file commits at end of cycle N+1 → busy clear takes effect in cycle N+2.
- Throughput: one write per cycle, no bubbles between back-to-back grants.
- Under continuous contention, grants alternate strictly pipe, lu, pipe, lu, ... starting with pipe after reset.

## Test plan
- Reset: hold rst for 2 cycles with random requests → en = 0, rd = 0, data = 0, all hazards 0; first contention after release grants pipe.
- Single write: pipe_valid = 1, pipe_rd = 5, pipe_data = 0xDEADBEEF in cycle N → pipe_ready = 1 in cycle N; en = 1, rd = 5, register_file_data = 0xDEADBEEF in cycle N+1; en = 0 in N+2.
- Contention: pipe (rd = 1, 0x11) and lu (rd = 2, 0x22) both held valid for 4 cycles → ready pattern pipe, lu, pipe, lu; output rd sequence 1, 2, 1, 2 with no idle cycles.
- Scoreboard: issue_rd = 7 in cycle N; rs1_address = 7 → hazard_rs1 = 1 from N+1. lu write rd = 7 granted in cycle M → hazard_rs1 stays 1 through M+1 and reads 0 in M+2. dec_rd = 7 → hazard_rd tracks the same window.
- x0: pipe write rd = 0, data = 0xFFFFFFFF → pipe_ready = 1, en stays 0. issue_rd = 0 with rs2_address = 0 → hazard_rs2 stays 0.
- Set/clear collision and reset: lu commit clearing rd = 9 at the same edge as issue_rd = 9 → hazard for 9 remains 1. Assert rst one cycle after a lu grant → no en pulse, all busy bits 0.
